transpose_pingpong: RTL and testbench
=====================================

// Module: transpose_pingpong
// PURPOSE
//  Streaming, double-buffered NxN transpose between DCT row and column stages.
//  Accepts one row of N signed samples per beat and emits one column per beat (or one row, per block mode).
//  Two banks alternate, so block k+1 fills while block k drains; output width reduction by wrap or saturate.
//  Sits between dct stage 1 and stage 2, and between stage 2 and quantisation.
// PARAMETERS
//  N      8   block dimension (rows, columns, elements per beat); N>=2
//  IN_W   10  signed input element width
//  OUT_W  10  signed output element width; OUT_W<=IN_W
// PORTS
//  clk       in   1          clock; single clock domain
//  rst_n     in   1          reset, asynchronous, active-low
//  in_valid  in   1          in_row valid
//  in_ready  out  1          block accepts a row this cycle
//  in_row    in   N*IN_W     row elements; element c at [c*IN_W +: IN_W]
//  tr_en     in   1          mode, sampled with first row of block: 1=emit columns, 0=emit rows
//  sat_en    in   1          per output beat: 1=saturate to OUT_W, 0=keep low OUT_W bits
//  out_valid out  1          out_vec valid
//  out_ready in   1          consumer accepts out_vec
//  out_vec   out  N*OUT_W    element j at [j*OUT_W +: OUT_W]
//  out_last  out  1          current beat is beat N-1 of its block
//  ovf       out  1          some element of current beat is out of OUT_W range
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-low.
//   rst_n low clears wr_bank, rd_bank, wr_row, rd_idx, full[1:0] and mode[1:0].
//   Resulting outputs: out_valid=0, out_last=0, ovf=0, in_ready=1.
//   Memory is not reset. A partial block in progress at reset is discarded.
//  Storage: mem[2][N][N] of IN_W-bit flops; full[b] marks bank b complete and readable.
//  Write side:
//   in_ready = !full[wr_bank]. Accept = in_valid & in_ready.
//   On accept: mem[wr_bank][wr_row] <= in_row.
//   If wr_row==0, mode[wr_bank] <= tr_en.
//   If wr_row==N-1: full[wr_bank] <= 1, wr_bank toggles, wr_row <= 0. Otherwise wr_row++.
//  Read side:
//   out_valid = full[rd_bank].
//   out_vec is combinational from the registers.
//   mode=1: element j = mem[rd_bank][j][rd_idx] (column rd_idx).
//   mode=0: element j = mem[rd_bank][rd_idx][j] (row rd_idx).
//   out_last = out_valid & (rd_idx==N-1).
//   On out_valid & out_ready: rd_idx++. At N-1: full[rd_bank] <= 0, rd_bank toggles, rd_idx <= 0.
//   out_vec and mode hold stable while out_valid & !out_ready.
//  Latency: first beat of a block is valid the cycle after its Nth row is accepted.
//  Throughput: 1 beat/cycle sustained with out_ready=1 (no bubbles between blocks).
//  Full/empty: both banks full -> in_ready=0 until a bank drains. Both empty -> out_valid=0.
//  Simultaneous events:
//   Fill completion on one bank and drain completion on the other in the same cycle are independent.
//   A bank freed at edge t is writable from cycle t+1; no same-cycle bypass from drain to fill.
//  Width rule, per element x (IN_W signed), with MAX=2^(OUT_W-1)-1 and MIN=-2^(OUT_W-1):
//   ovf_e = (x>MAX)|(x<MIN). ovf = out_valid & OR of ovf_e across the beat, independent of sat_en.
//   sat_en=1: y = clamp(x,MIN,MAX). sat_en=0: y = x[OUT_W-1:0].
//   With OUT_W==IN_W: y=x and ovf=0.
//  in_row, tr_en and sat_en are don't-care when not in use; X on them must not corrupt state.
// TESTING (N=8, IN_W=12, OUT_W=11 unless noted)
//  1. Reset; one block in[r][c]=8r+c, tr_en=1, out_ready=1.
//     -> out_valid rises the cycle after the 8th accept; beat k element j = 8j+k; out_last only on beat 7.
//  2. Three blocks back-to-back, in_valid=1, out_ready=1.
//     -> in_ready never drops; 24 contiguous output beats; blocks in order with correct data.
//  3. out_ready=0, rows streamed.
//     -> in_ready=0 after 16 accepts; the 17th row is held. Raise out_ready -> both blocks correct; 17th row lands in bank 0.
//  4. Element 1500 with sat_en=1 -> 1023, ovf=1. With sat_en=0 -> -548, ovf=1.
//     Element -1025 with sat_en=1 -> -1024. Element 100 -> 100, ovf=0.
//  5. Block A with tr_en=0, block B with tr_en=1, tr_en toggled mid-block.
//     -> A emitted as rows, B as columns; mode follows the first row only.
//  6. rst_n low after 5 rows, and again while draining.
//     -> out_valid=0 immediately; in_ready=1; next block needs all 8 rows; no stale beats emitted.

Source files
------------

// File: rtl/transpose_pingpong_if.sv
// Row-in / vector-out streaming bus for the ping-pong transpose buffer.
// master = producer/consumer side, slave = the transpose block.
interface transpose_pingpong_if #(
  parameter int N     = 8,
  parameter int IN_W  = 10,
  parameter int OUT_W = 10
);
  logic               in_valid;
  logic               in_ready;
  logic [N*IN_W-1:0]  in_row;
  logic               tr_en;
  logic               sat_en;
  logic               out_valid;
  logic               out_ready;
  logic [N*OUT_W-1:0] out_vec;
  logic               out_last;
  logic               ovf;

  modport master (
    output in_valid, in_row, tr_en, sat_en, out_ready,
    input  in_ready, out_valid, out_vec, out_last, ovf
  );

  modport slave (
    input  in_valid, in_row, tr_en, sat_en, out_ready,
    output in_ready, out_valid, out_vec, out_last, ovf
  );
endinterface

// File: rtl/transpose_pingpong.sv
// Double-buffered NxN transpose: one bank fills row by row while the other
// drains as columns (or rows), with wrap/saturate narrowing on the output.
module transpose_pingpong #(
  parameter int N     = 8,
  parameter int IN_W  = 10,
  parameter int OUT_W = 10
) (
  input logic                 clk,
  input logic                 rst_n,
  transpose_pingpong_if.slave bus
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  localparam logic signed [IN_W-1:0] MAX_X = IN_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] MIN_X = IN_W'(-(1 << (OUT_W - 1)));

  logic [IN_W-1:0]   mem [2][N][N];
  logic              wr_bank;
  logic              rd_bank;
  logic [IDX_W-1:0]  wr_row;
  logic [IDX_W-1:0]  rd_idx;
  logic [1:0]        full;
  logic [1:0]        full_nxt;
  logic [1:0]        mode;

  logic              in_ready_i;
  logic              out_valid_i;
  logic              accept;
  logic              drain;
  logic              fill_done;
  logic              drain_done;

  logic signed [IN_W-1:0] lane_x [N];
  logic [N-1:0]           ovf_e;
  logic [N*OUT_W-1:0]     vec;

  assign in_ready_i  = !full[wr_bank];
  assign out_valid_i = full[rd_bank];
  assign accept      = bus.in_valid & in_ready_i;
  assign drain       = out_valid_i & bus.out_ready;
  assign fill_done   = accept & (wr_row == LAST);
  assign drain_done  = drain & (rd_idx == LAST);

  // Fill and drain always touch different banks, so both edits can apply together.
  always_comb begin
    full_nxt = full;
    if (fill_done)  full_nxt[wr_bank] = 1'b1;
    if (drain_done) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_row  <= '0;
      rd_idx  <= '0;
      full    <= '0;
      mode    <= '0;
    end else begin
      full <= full_nxt;
      if (accept) begin
        if (wr_row == '0) mode[wr_bank] <= bus.tr_en;
        if (fill_done) begin
          wr_bank <= !wr_bank;
          wr_row  <= '0;
        end else begin
          wr_row  <= wr_row + IDX_W'(1);
        end
      end
      if (drain) begin
        if (drain_done) begin
          rd_bank <= !rd_bank;
          rd_idx  <= '0;
        end else begin
          rd_idx  <= rd_idx + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < N; c++) begin
        mem[wr_bank][wr_row][c] <= bus.in_row[c*IN_W +: IN_W];
      end
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_lane
    assign lane_x[j] = mode[rd_bank] ? mem[rd_bank][j][rd_idx] : mem[rd_bank][rd_idx][j];
  end

  // Range flag is independent of sat_en; sat_en only picks clamp versus wrap.
  always_comb begin
    vec   = '0;
    ovf_e = '0;
    for (int j = 0; j < N; j++) begin
      ovf_e[j] = (lane_x[j] > MAX_X) | (lane_x[j] < MIN_X);
      if (bus.sat_en && (lane_x[j] > MAX_X))
        vec[j*OUT_W +: OUT_W] = MAX_X[OUT_W-1:0];
      else if (bus.sat_en && (lane_x[j] < MIN_X))
        vec[j*OUT_W +: OUT_W] = MIN_X[OUT_W-1:0];
      else
        vec[j*OUT_W +: OUT_W] = lane_x[j][OUT_W-1:0];
    end
  end

  assign bus.in_ready  = in_ready_i;
  assign bus.out_valid = out_valid_i;
  assign bus.out_vec   = vec;
  assign bus.out_last  = out_valid_i & (rd_idx == LAST);
  assign bus.ovf       = out_valid_i & (|ovf_e);
endmodule

// File: tb/tb_transpose_pingpong.sv
// Randomized bench for transpose_pingpong against a block-queue reference model.
module tb_transpose_pingpong;
  localparam int N     = 8;
  localparam int IN_W  = 12;
  localparam int OUT_W = 11;

  logic clk;
  logic rst_n;

  transpose_pingpong_if #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  transpose_pingpong #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: completed blocks queued in arrival order, 64 ints each
  int q_d[$];
  bit q_m[$];
  int cur_d[64];
  bit cur_m;
  int cur_rows;
  int rd_k;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q_d.delete();
    q_m.delete();
    cur_rows = 0;
    rd_k = 0;
  endtask

  task automatic check_outputs(input bit sat);
    int pend;
    int x;
    int y;
    bit o;
    logic [N*OUT_W-1:0] ev;
    pend = q_m.size();
    chk("in_ready", bus.in_ready, pend < 2);
    chk("out_valid", bus.out_valid, pend > 0);
    if (pend > 0) begin
      o = 1'b0;
      ev = '0;
      for (int j = 0; j < N; j++) begin
        x = q_m[0] ? q_d[j*N + rd_k] : q_d[rd_k*N + j];
        if (x > 1023 || x < -1024) o = 1'b1;
        if (sat) y = (x > 1023) ? 1023 : ((x < -1024) ? -1024 : x);
        else     y = x;
        ev[j*OUT_W +: OUT_W] = y[OUT_W-1:0];
      end
      chk("out_vec", bus.out_vec, ev);
      chk("out_last", bus.out_last, rd_k == N - 1);
      chk("ovf", bus.ovf, o);
    end else begin
      chk("out_last_idle", bus.out_last, 1'b0);
      chk("ovf_idle", bus.ovf, 1'b0);
    end
  endtask

  // kind 0: random data, 1: 8r+c, 2: saturation pattern
  task automatic step(input int v_pct, input int r_pct, input int kind, input int tr_first, input int sat_pct);
    logic [N*IN_W-1:0] row;
    logic signed [IN_W-1:0] s;
    bit v, r, tr, sat, acc, hs;
    int val;
    v = ($urandom_range(0, 99) < v_pct);
    r = ($urandom_range(0, 99) < r_pct);
    sat = ($urandom_range(0, 99) < sat_pct);
    tr = (tr_first >= 0 && cur_rows == 0) ? tr_first[0] : 1'($urandom_range(0, 1));
    for (int c = 0; c < N; c++) begin
      case (kind)
        1: val = 8 * cur_rows + c;
        2: val = (cur_rows == 0 && c == 0) ? 1500 : ((cur_rows == 0 && c == 1) ? -1025 : 100);
        default: val = $urandom_range(0, 1) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 200)) - 100;
      endcase
      row[c*IN_W +: IN_W] = val[IN_W-1:0];
    end
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_row    = v ? row : 'x;
    bus.tr_en     = v ? tr : 1'bx;
    bus.sat_en    = sat;
    bus.out_ready = r;
    #1;
    check_outputs(sat);
    acc = v && (q_m.size() < 2);
    hs  = r && (q_m.size() > 0);
    @(posedge clk);
    if (hs) begin
      rd_k++;
      if (rd_k == N) begin
        repeat (N * N) void'(q_d.pop_front());
        void'(q_m.pop_front());
        rd_k = 0;
      end
    end
    if (acc) begin
      for (int c = 0; c < N; c++) begin
        s = row[c*IN_W +: IN_W];
        cur_d[cur_rows*N + c] = int'(s);
      end
      if (cur_rows == 0) cur_m = tr;
      cur_rows++;
      if (cur_rows == N) begin
        for (int i = 0; i < N * N; i++) q_d.push_back(cur_d[i]);
        q_m.push_back(cur_m);
        cur_rows = 0;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q_m.size() > 0; i++) step(0, 100, 0, -1, 50);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("drain_empty", bus.out_valid, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_last", bus.out_last, 1'b0);
    chk("rst_ovf", bus.ovf, 1'b0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_row    = '0;
    bus.tr_en     = 1'b0;
    bus.sat_en    = 1'b0;
    bus.out_ready = 1'b0;
    model_clear();
    #12;
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_in_ready", bus.in_ready, 1'b1);
    chk("reset_out_last", bus.out_last, 1'b0);
    chk("reset_ovf", bus.ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // one 8r+c block emitted as columns
    repeat (8) step(100, 100, 1, 1, 50);
    drain();

    // three blocks back to back
    repeat (24) step(100, 100, 0, -1, 50);
    drain();

    // consumer stalled: 16 rows fit, the 17th waits for bank 0
    repeat (19) step(100, 0, 0, -1, 50);
    repeat (20) step(100, 100, 0, -1, 50);
    drain();
    if (cur_rows != 0) begin
      repeat (N - cur_rows) step(100, 0, 0, -1, 50);
      drain();
    end

    // width reduction on a held beat
    repeat (8) step(100, 0, 2, 0, 0);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.sat_en    = 1'b1;
    #1;
    chk("sat_hi", bus.out_vec[10:0], 11'd1023);
    chk("sat_lo", bus.out_vec[21:11], 11'h400);
    chk("sat_mid", bus.out_vec[32:22], 11'd100);
    chk("sat_ovf", bus.ovf, 1'b1);
    bus.sat_en = 1'b0;
    #1;
    chk("wrap_hi", bus.out_vec[10:0], 11'h5DC);
    chk("wrap_lo", bus.out_vec[21:11], 11'h3FF);
    chk("wrap_ovf", bus.ovf, 1'b1);
    drain();

    // rows block then columns block, tr_en jittering after the first row
    repeat (8) step(100, 0, 0, 0, 50);
    repeat (8) step(100, 0, 0, 1, 50);
    drain();

    // reset mid-fill, then a fresh block needs all 8 rows
    repeat (5) step(100, 100, 0, -1, 50);
    do_reset();
    repeat (7) step(100, 100, 0, -1, 50);
    step(100, 100, 0, -1, 50);
    drain();

    // reset while draining leaves nothing behind
    repeat (8) step(100, 0, 0, -1, 50);
    repeat (3) step(0, 100, 0, -1, 50);
    do_reset();
    repeat (4) step(0, 100, 0, -1, 50);

    // random traffic
    repeat (400) step(60, 60, 0, -1, 50);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
